sisc_fetch: RTL
===============

SISC_FETCH -- requirements
Module: sisc_fetch

Interface
REQ-001 Parameter AW, default 16, instruction address width in words.
REQ-002 Parameter RESET_PC, default 0, PC value loaded at reset.
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 RST_F  input  1  reset, asynchronous, active-low.
REQ-005 fetch_req  input  1  control unit requests the next instruction; sampled only in IDLE.
REQ-006 br_en  input  1  branch/jump taken; loads PC from br_addr.
REQ-007 br_addr  input  AW  branch target word address.
REQ-008 halt  input  1  stop issuing new fetches; sticky until reset.
REQ-009 imem_rd  output  1  instruction memory read request.
REQ-010 imem_addr  output  AW  instruction memory word address.
REQ-011 imem_data  input  32  instruction memory read data, valid with imem_ack.
REQ-012 imem_ack  input  1  one-cycle read completion from memory, 1 or more cycles after imem_rd rises.
REQ-013 ir  output  32  instruction register.
REQ-014 ir_valid  output  1  one-cycle pulse: ir was updated this cycle.
REQ-015 pc  output  AW  address of next instruction to fetch.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 halted  output  1  sticky halt flag.
REQ-018 fetch_cnt  output  16  count of completed (non-discarded) fetches.

Function
REQ-019 FSM states: IDLE, REQ, FLUSH; all outputs registered.
REQ-020 IDLE, fetch_req=1, br_en=0, halted=0: next cycle state REQ, imem_rd=1, imem_addr=pc (latched in a request-address register).
REQ-021 REQ: imem_rd and imem_addr held constant until the cycle imem_ack=1.
REQ-022 REQ with imem_ack=1, br_en=0: next cycle ir=imem_data, ir_valid=1, pc=pc+1, fetch_cnt+1, imem_rd=0, state IDLE.
REQ-023 Fetch latency: ir_valid rises exactly 1 cycle after the imem_ack cycle; minimum 2 cycles from fetch_req to ir_valid.
REQ-024 ir_valid high for exactly one cycle per completed fetch; ir holds its value until the next completed fetch.
REQ-025 pc increment wraps modulo 2^AW (all-ones + 1 = 0); fetch_cnt wraps 16'hFFFF -> 0.
REQ-026 br_en=1 in any state: next cycle pc=br_addr; br_en takes priority over the pc increment.
REQ-027 IDLE with br_en=1 and fetch_req=1 in the same cycle: branch applied, fetch_req ignored, state remains IDLE.
REQ-028 REQ with br_en=1 and imem_ack=1 in the same cycle: data discarded, ir unchanged, ir_valid=0, fetch_cnt unchanged, state IDLE.
REQ-029 REQ with br_en=1 and imem_ack=0: state FLUSH; imem_rd/imem_addr continue to be held at the original request.
REQ-030 FLUSH: on imem_ack, data discarded, ir_valid=0, imem_rd=0, state IDLE; further br_en in FLUSH updates pc only.
REQ-031 fetch_req outside IDLE is ignored (no queuing).
REQ-032 halt=1 sets halted the next cycle; while halted, IDLE ignores fetch_req; an in-flight REQ/FLUSH completes normally.
REQ-033 Memory handshake is never abandoned: once imem_rd rises, it stays high until imem_ack, except on reset.

Reset
REQ-034 RST_F low asynchronously forces: state IDLE, pc=RESET_PC, imem_rd=0, imem_addr=0, ir=0, ir_valid=0, fetch_cnt=0, halted=0, busy=0.
REQ-035 Reset asserted mid-fetch aborts the request immediately; a late imem_ack after reset release in IDLE is ignored.
REQ-036 First fetch_req is honoured in the first rising edge after RST_F deasserts.

Verification
REQ-037 Reset, fetch_req pulse, memory acks after 3 cycles with 32'hA5A5_0001 -> imem_addr=0 held 3 cycles, ir=32'hA5A5_0001, ir_valid one cycle, pc=1, fetch_cnt=1.
REQ-038 pc preset to 16'hFFFF via br_en, then one fetch -> imem_addr=16'hFFFF, pc wraps to 0 after ack.
REQ-039 br_en with br_addr=16'h0040 during REQ, ack 2 cycles later -> FLUSH entered, imem_rd held, ir unchanged, no ir_valid, pc=16'h0040, next fetch reads 16'h0040.
REQ-040 br_en and imem_ack same cycle -> data discarded, pc=br_addr, fetch_cnt unchanged.
REQ-041 halt asserted during REQ -> fetch completes with ir_valid, halted=1, subsequent fetch_req produces no imem_rd.
REQ-042 RST_F pulled low mid-REQ -> all outputs at reset values asynchronously; stray imem_ack after release ignored.

Source files
------------

// File: rtl/sisc_fetch.sv
// SISC instruction fetch unit: a three-state fetch FSM that issues single-word
// instruction memory reads, handles branch redirects and sticky halt.
module sisc_fetch #(
   parameter int unsigned   AW       = 16,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          CLK,
   input  logic          RST_F,
   input  logic          fetch_req,
   input  logic          br_en,
   input  logic [AW-1:0] br_addr,
   input  logic          halt,
   output logic          imem_rd,
   output logic [AW-1:0] imem_addr,
   input  logic [31:0]   imem_data,
   input  logic          imem_ack,
   output logic [31:0]   ir,
   output logic          ir_valid,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          halted,
   output logic [15:0]   fetch_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t        r_state,      w_state_nxt;
   logic [AW-1:0] r_pc,         w_pc_nxt;
   logic [AW-1:0] r_req_addr,   w_req_addr_nxt;
   logic          r_rd,         w_rd_nxt;
   logic [31:0]   r_ir,         w_ir_nxt;
   logic          r_ir_valid,   w_ir_valid_nxt;
   logic [15:0]   r_fetch_cnt,  w_fetch_cnt_nxt;
   logic          r_halted,     w_halted_nxt;

   // NOTE: every register takes the async reset; non-blocking assignments keep
   // all state updating together on the same edge.
   always_ff @(posedge CLK or negedge RST_F) begin
      if (!RST_F) begin
         r_state     <= S_IDLE;
         r_pc        <= RESET_PC;
         r_req_addr  <= '0;
         r_rd        <= 1'b0;
         r_ir        <= '0;
         r_ir_valid  <= 1'b0;
         r_fetch_cnt <= '0;
         r_halted    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_req_addr  <= w_req_addr_nxt;
         r_rd        <= w_rd_nxt;
         r_ir        <= w_ir_nxt;
         r_ir_valid  <= w_ir_valid_nxt;
         r_fetch_cnt <= w_fetch_cnt_nxt;
         r_halted    <= w_halted_nxt;
      end
   end

   // NOTE: every next-value starts from a hold/default so no path infers a latch.
   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_req_addr_nxt  = r_req_addr;
      w_rd_nxt        = r_rd;
      w_ir_nxt        = r_ir;
      w_ir_valid_nxt  = 1'b0;
      w_fetch_cnt_nxt = r_fetch_cnt;
      w_halted_nxt    = r_halted | halt;

      unique case (r_state)
         S_IDLE: begin
            if (br_en) begin
               w_pc_nxt = br_addr;
            end else if (fetch_req && !r_halted) begin
               w_state_nxt    = S_REQ;
               w_rd_nxt       = 1'b1;
               w_req_addr_nxt = r_pc;
            end
         end

         S_REQ: begin
            if (imem_ack) begin
               w_state_nxt = S_IDLE;
               w_rd_nxt    = 1'b0;
               if (br_en) begin
                  w_pc_nxt = br_addr;
               end else begin
                  w_ir_nxt        = imem_data;
                  w_ir_valid_nxt  = 1'b1;
                  w_pc_nxt        = r_pc + 1'b1;
                  w_fetch_cnt_nxt = r_fetch_cnt + 16'd1;
               end
            end else if (br_en) begin
               // Redirected while the read is outstanding: keep the handshake
               // alive and throw the returning word away.
               w_state_nxt = S_FLUSH;
               w_pc_nxt    = br_addr;
            end
         end

         S_FLUSH: begin
            if (br_en) begin
               w_pc_nxt = br_addr;
            end
            if (imem_ack) begin
               w_state_nxt = S_IDLE;
               w_rd_nxt    = 1'b0;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_rd_nxt    = 1'b0;
         end
      endcase
   end

   assign imem_rd   = r_rd;
   assign imem_addr = r_req_addr;
   assign ir        = r_ir;
   assign ir_valid  = r_ir_valid;
   assign pc        = r_pc;
   assign busy      = (r_state != S_IDLE);
   assign halted    = r_halted;
   assign fetch_cnt = r_fetch_cnt;

endmodule
